// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer (FETCH/EX/MEM/WB/TRAP) that drives the
// instruction and data buses around an external decoder, ALU and register file.
module cpu_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          SHORTCIRCUIT = 1,
    parameter int unsigned TIMEOUT      = 0,
    parameter int unsigned RETIRE_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_valid,
    input  logic [31:0]         imem_rdata,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [31:0]         dmem_addr,
    output logic [31:0]         dmem_wdata,
    output logic [1:0]          dmem_oplen,
    output logic                dmem_unsigned,
    input  logic                dmem_valid,
    input  logic [31:0]         dmem_rdata,
    output logic [31:0]         instr,
    input  logic [6:0]          dec_op,
    input  logic [2:0]          dec_func3,
    input  logic [31:0]         dec_imm,
    input  logic [1:0]          dec_oplen,
    input  logic [31:0]         alu_result,
    input  logic [31:0]         rf_rs2,
    output logic                rf_we,
    output logic [31:0]         rf_wdata,
    output logic [31:0]         pc,
    output logic                halted,
    output logic [2:0]          trap_cause,
    output logic [RETIRE_W-1:0] retired
);
    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_EX    = 3'd1;
    localparam logic [2:0] S_MEM   = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_TRAP  = 3'd4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0]         NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0]         WAIT_LAST  = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);
    localparam logic [RETIRE_W-1:0] RETIRE_ONE = RETIRE_W'(1);

    logic [2:0]  state;
    logic [31:0] wait_cnt;
    logic [31:0] next_pc_q;
    logic        op_legal;
    logic        is_load, is_store, is_mem, wb_en, timeout_hit;
    logic [31:0] ex_next_pc, ex_wdata;
    logic [2:0]  ex_cause;
    logic        unused_func3_bit;

    assign unused_func3_bit = dec_func3[1];

    assign is_load     = (dec_op == OP_LOAD);
    assign is_store    = (dec_op == OP_STORE);
    assign is_mem      = is_load || is_store;
    assign wb_en       = !(is_store || dec_op == OP_BRANCH || dec_op == OP_MISC);
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

    always_comb begin
        // NOTE: every always_comb output is given a default first so no latch is inferred.
        op_legal = 1'b0;
        case (dec_op)
            OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_LUI,
            OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_MISC: op_legal = 1'b1;
            default:                                       op_legal = 1'b0;
        endcase
    end

    always_comb begin
        ex_next_pc = pc + 32'd4;
        ex_wdata   = alu_result;
        case (dec_op)
            OP_JAL: begin
                ex_next_pc = pc + dec_imm;
                ex_wdata   = pc + 32'd4;
            end
            OP_JALR: begin
                ex_next_pc = {alu_result[31:1], 1'b0};
                ex_wdata   = pc + 32'd4;
            end
            OP_BRANCH: if (alu_result[0] != dec_func3[0]) ex_next_pc = pc + dec_imm;
            OP_LOAD:   ex_wdata = 32'd0;
            default:   ;
        endcase

        ex_cause = 3'd0;
        if (dec_op == OP_SYSTEM)          ex_cause = 3'd2;
        else if (!op_legal)               ex_cause = 3'd1;
        else if (ex_next_pc[1:0] != 2'b0) ex_cause = 3'd4;
    end

    // NOTE: state updates use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            next_pc_q  <= RESET_PC;
            instr      <= NOP_INSTR;
            rf_wdata   <= 32'd0;
            trap_cause <= 3'd0;
            retired    <= '0;
            wait_cnt   <= 32'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_valid) begin
                        instr    <= imem_rdata;
                        state    <= S_EX;
                        wait_cnt <= 32'd0;
                    end else if (timeout_hit) begin
                        state      <= S_TRAP;
                        trap_cause <= 3'd3;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_EX: begin
                    next_pc_q <= ex_next_pc;
                    rf_wdata  <= ex_wdata;
                    wait_cnt  <= 32'd0;
                    if (ex_cause != 3'd0) begin
                        state      <= S_TRAP;
                        trap_cause <= ex_cause;
                    end else if (is_mem || SHORTCIRCUIT == 0) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (!is_mem) begin
                        state <= S_WB;
                    end else if (dmem_valid) begin
                        if (is_load) rf_wdata <= dmem_rdata;
                        state <= S_WB;
                    end else if (timeout_hit) begin
                        state      <= S_TRAP;
                        trap_cause <= 3'd3;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_WB: begin
                    pc       <= next_pc_q;
                    retired  <= retired + RETIRE_ONE;
                    wait_cnt <= 32'd0;
                    state    <= S_FETCH;
                end
                S_TRAP:  ;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Strobes are qualified with rst so an outstanding request drops as soon as reset is seen.
    assign imem_req      = !rst && (state == S_FETCH);
    assign imem_addr     = pc;
    assign dmem_req      = !rst && (state == S_MEM) && is_mem;
    assign dmem_we       = dmem_req && is_store;
    assign dmem_addr     = alu_result;
    assign dmem_wdata    = rf_rs2;
    assign dmem_oplen    = dec_oplen;
    assign dmem_unsigned = dec_func3[2];
    assign rf_we         = !rst && (state == S_WB) && wb_en;
    assign halted        = !rst && (state == S_TRAP);
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a cycle-level expectation model driven by
// instruction-level predictions, plus literal checks of the headline scenarios.
module tb_cpu_sequencer;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_BAD    = 7'h7F;

    typedef struct packed {
        logic [2:0]  cause;
        logic [31:0] npc;
        logic [31:0] wdata;
        logic        writes;
        logic        mem;
        logic        store;
    } pred_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        dmem_valid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic [6:0]  dec_op = OP_IMM;
    logic [2:0]  dec_func3 = 3'd0;
    logic [31:0] dec_imm = 32'd0;
    logic [1:0]  dec_oplen = 2'd0;
    logic [31:0] alu_result = 32'd0;
    logic [31:0] rf_rs2 = 32'd0;

    logic        imem_req, dmem_req, dmem_we, dmem_unsigned, rf_we, halted;
    logic [31:0] imem_addr, dmem_addr, dmem_wdata, instr, rf_wdata, pc;
    logic [1:0]  dmem_oplen;
    logic [2:0]  trap_cause;
    logic [3:0]  retired;

    logic        ns_imem_req, ns_dmem_req, ns_dmem_we, ns_dmem_unsigned, ns_rf_we, ns_halted;
    logic [31:0] ns_imem_addr, ns_dmem_addr, ns_dmem_wdata, ns_instr, ns_rf_wdata, ns_pc;
    logic [1:0]  ns_dmem_oplen;
    logic [2:0]  ns_trap_cause;
    logic [31:0] ns_retired;

    cpu_sequencer #(.RESET_PC(RST_PC), .SHORTCIRCUIT(1), .TIMEOUT(8), .RETIRE_W(4)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_oplen(dmem_oplen), .dmem_unsigned(dmem_unsigned), .dmem_valid(dmem_valid), .dmem_rdata(dmem_rdata),
        .instr(instr), .dec_op(dec_op), .dec_func3(dec_func3), .dec_imm(dec_imm), .dec_oplen(dec_oplen),
        .alu_result(alu_result), .rf_rs2(rf_rs2), .rf_we(rf_we), .rf_wdata(rf_wdata),
        .pc(pc), .halted(halted), .trap_cause(trap_cause), .retired(retired)
    );

    cpu_sequencer #(.RESET_PC(RST_PC), .SHORTCIRCUIT(0), .TIMEOUT(0), .RETIRE_W(32)) u_ns (
        .clk(clk), .rst(rst),
        .imem_req(ns_imem_req), .imem_addr(ns_imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .dmem_req(ns_dmem_req), .dmem_we(ns_dmem_we), .dmem_addr(ns_dmem_addr), .dmem_wdata(ns_dmem_wdata),
        .dmem_oplen(ns_dmem_oplen), .dmem_unsigned(ns_dmem_unsigned), .dmem_valid(dmem_valid), .dmem_rdata(dmem_rdata),
        .instr(ns_instr), .dec_op(dec_op), .dec_func3(dec_func3), .dec_imm(dec_imm), .dec_oplen(dec_oplen),
        .alu_result(alu_result), .rf_rs2(rf_rs2), .rf_we(ns_rf_we), .rf_wdata(ns_rf_wdata),
        .pc(ns_pc), .halted(ns_halted), .trap_cause(ns_trap_cause), .retired(ns_retired)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Expected outputs for the current cycle, updated by the stimulus just after each rising edge.
    bit          chk_on = 1'b0;
    logic        e_imem_req = 1'b0, e_dmem_req = 1'b0, e_dmem_we = 1'b0, e_unsigned = 1'b0;
    logic        e_rf_we = 1'b0, e_halted = 1'b0;
    logic [31:0] e_pc = RST_PC, e_instr = 32'h13, e_wdata = 32'd0;
    logic [31:0] e_dmem_addr = 32'd0, e_dmem_wdata = 32'd0;
    logic [1:0]  e_oplen = 2'd0;
    logic [2:0]  e_cause = 3'd0;
    logic [3:0]  e_retired = 4'd0;

    always @(negedge clk) begin
        if (chk_on) begin
            check("imem_req", imem_req, e_imem_req);
            check("pc", pc, e_pc);
            if (e_imem_req) check("imem_addr", imem_addr, e_pc);
            check("instr", instr, e_instr);
            check("dmem_req", dmem_req, e_dmem_req);
            check("dmem_we", dmem_we, e_dmem_we);
            if (e_dmem_req) begin
                check("dmem_addr", dmem_addr, e_dmem_addr);
                check("dmem_oplen", 32'(dmem_oplen), 32'(e_oplen));
                check("dmem_unsigned", dmem_unsigned, e_unsigned);
                if (e_dmem_we) check("dmem_wdata", dmem_wdata, e_dmem_wdata);
            end
            check("rf_we", rf_we, e_rf_we);
            if (e_rf_we || rst) check("rf_wdata", rf_wdata, e_wdata);
            check("halted", halted, e_halted);
            check("trap_cause", 32'(trap_cause), 32'(e_cause));
            check("retired", 32'(retired), 32'(e_retired));
        end
    end

    // First write-back cycle after the first reset release, for both short-circuit settings.
    int lat_cnt = 0, sc_lat = 0, ns_lat = 0;
    always @(negedge clk) begin
        if (rst) begin
            lat_cnt = 0;
        end else begin
            lat_cnt++;
            if (rf_we && sc_lat == 0) sc_lat = lat_cnt;
            if (ns_rf_we && ns_lat == 0) ns_lat = lat_cnt;
        end
    end

    function automatic pred_t predict(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] imm,
                                      input logic [31:0] alu, input logic [31:0] cur_pc, input logic [31:0] rdata);
        pred_t p;
        p = '0;
        p.npc = cur_pc + 32'd4;
        if (op == OP_JAL) p.npc = cur_pc + imm;
        if (op == OP_JALR) p.npc = alu & ~32'd1;
        if (op == OP_BRANCH && (alu[0] ^ f3[0])) p.npc = cur_pc + imm;
        if (op == OP_SYSTEM) p.cause = 3'd2;
        else if (!(op inside {OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_LUI, OP_AUIPC,
                              OP_JAL, OP_JALR, OP_BRANCH, OP_MISC})) p.cause = 3'd1;
        else if (p.npc % 4 != 0) p.cause = 3'd4;
        p.mem    = (op == OP_LOAD) || (op == OP_STORE);
        p.store  = (op == OP_STORE);
        p.writes = !(op inside {OP_STORE, OP_BRANCH, OP_MISC});
        p.wdata  = (op == OP_JAL || op == OP_JALR) ? cur_pc + 32'd4 : (op == OP_LOAD) ? rdata : alu;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        chk_on = 1'b0;
        step();
        e_imem_req = 1'b0; e_dmem_req = 1'b0; e_dmem_we = 1'b0; e_rf_we = 1'b0; e_halted = 1'b0;
        e_pc = RST_PC; e_instr = 32'h13; e_wdata = 32'd0; e_cause = 3'd0; e_retired = 4'd0;
        chk_on = 1'b1;
        step();
        rst = 1'b0;
        e_imem_req = 1'b1;
    endtask

    // Issues one instruction starting in a FETCH cycle with zero fetch wait; the data
    // memory answers after 'waits' cycles, or reset is raised instead when 'abort' is set.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] imm,
                             input logic [31:0] alu, input logic [31:0] rs2, input int waits,
                             input logic [31:0] rdata, input bit abort);
        pred_t       p;
        logic [31:0] word;
        word = {imm[19:0], alu[4:0], op};
        p = predict(op, f3, imm, alu, e_pc, rdata);
        imem_valid = 1'b1; imem_rdata = word; dmem_valid = 1'b0; dmem_rdata = rdata;
        dec_op = op; dec_func3 = f3; dec_imm = imm; dec_oplen = f3[1:0];
        alu_result = alu; rf_rs2 = rs2;
        e_imem_req = 1'b1;
        step();
        imem_valid = 1'b0;
        e_imem_req = 1'b0;
        e_instr = word;
        step();
        if (p.cause != 3'd0) begin
            e_halted = 1'b1;
            e_cause = p.cause;
            for (int i = 0; i < 3; i++) begin
                imem_valid = 1'b1;
                dmem_valid = 1'b1;
                step();
            end
            imem_valid = 1'b0;
            dmem_valid = 1'b0;
            return;
        end
        for (int w = 0; w < (p.mem ? waits + 1 : 0); w++) begin
            e_dmem_req = 1'b1; e_dmem_we = p.store; e_dmem_addr = alu; e_dmem_wdata = rs2;
            e_oplen = f3[1:0]; e_unsigned = f3[2];
            if (abort && w == waits) begin
                rst = 1'b1;
                chk_on = 1'b0;
                step();
                check("abort_dmem_req", 32'(dmem_req), 32'd0);
                check("abort_pc", pc, RST_PC);
                check("abort_rf_we", 32'(rf_we), 32'd0);
                return;
            end
            dmem_valid = (w == waits);
            step();
        end
        dmem_valid = 1'b0;
        e_dmem_req = 1'b0; e_dmem_we = 1'b0;
        e_rf_we = p.writes; e_wdata = p.wdata;
        step();
        e_rf_we = 1'b0;
        e_pc = p.npc;
        e_retired = e_retired + 4'd1;
        e_imem_req = 1'b1;
    endtask

    initial begin
        do_reset();
        check("reset_imem_addr", imem_addr, 32'h100);
        run_instr(OP_IMM, 3'b000, 32'd1, 32'd1, 32'd0, 0, 32'd0, 1'b0);
        check("addi_pc", pc, 32'h104);
        check("addi_retired", 32'(retired), 32'd1);

        run_instr(OP_JAL, 3'b000, -32'sd196, 32'd0, 32'd0, 0, 32'd0, 1'b0);
        check("jal_back_pc", pc, 32'h40);
        run_instr(OP_BRANCH, 3'b000, -32'sd8, 32'd1, 32'd0, 0, 32'd0, 1'b0);
        check("beq_taken_pc", pc, 32'h38);
        run_instr(OP_IMM, 3'b000, 32'd5, 32'h55, 32'd0, 0, 32'd0, 1'b0);
        run_instr(OP_REG, 3'b111, 32'd0, 32'hA5A5_0F0F, 32'd0, 0, 32'd0, 1'b0);
        run_instr(OP_JAL, 3'b000, 32'h10, 32'd0, 32'd0, 0, 32'd0, 1'b0);
        check("jal_pc", pc, 32'h50);
        check("jal_link", rf_wdata, 32'h44);
        run_instr(OP_BRANCH, 3'b001, 32'h20, 32'd1, 32'd0, 0, 32'd0, 1'b0);
        check("bne_not_taken_pc", pc, 32'h54);
        run_instr(OP_LOAD, 3'b010, 32'd0, 32'h2000, 32'd0, 5, 32'hDEAD_BEEF, 1'b0);
        check("load_data", rf_wdata, 32'hDEAD_BEEF);
        run_instr(OP_LOAD, 3'b101, 32'd0, 32'h2002, 32'd0, 0, 32'h0000_8001, 1'b0);
        run_instr(OP_STORE, 3'b010, 32'd0, 32'h3004, 32'hCAFE_0001, 2, 32'd0, 1'b0);
        run_instr(OP_LUI, 3'b000, 32'd0, 32'h1234_5000, 32'd0, 0, 32'd0, 1'b0);
        run_instr(OP_AUIPC, 3'b000, 32'd0, 32'h0000_1068, 32'd0, 0, 32'd0, 1'b0);
        run_instr(OP_MISC, 3'b000, 32'd0, 32'd0, 32'd0, 0, 32'd0, 1'b0);
        run_instr(OP_JALR, 3'b000, 32'd0, 32'h201, 32'd0, 0, 32'd0, 1'b0);
        check("jalr_pc", pc, 32'h200);

        do_reset();
        run_instr(OP_BAD, 3'b000, 32'd0, 32'd0, 32'd0, 0, 32'd0, 1'b0);
        check("illegal_cause", 32'(trap_cause), 32'd1);
        check("illegal_halted", 32'(halted), 32'd1);
        check("illegal_retired", 32'(retired), 32'd0);

        do_reset();
        run_instr(OP_JALR, 3'b000, 32'd0, 32'h103, 32'd0, 0, 32'd0, 1'b0);
        check("misalign_cause", 32'(trap_cause), 32'd4);
        check("misalign_pc", pc, 32'h100);

        do_reset();
        run_instr(OP_SYSTEM, 3'b000, 32'd0, 32'd0, 32'd0, 0, 32'd0, 1'b0);
        check("system_cause", 32'(trap_cause), 32'd2);

        do_reset();
        for (int i = 0; i < 7; i++) step();
        step();
        e_imem_req = 1'b0; e_halted = 1'b1; e_cause = 3'd3;
        for (int i = 0; i < 3; i++) step();
        check("timeout_cause", 32'(trap_cause), 32'd3);
        check("timeout_imem_req", 32'(imem_req), 32'd0);

        do_reset();
        for (int i = 0; i < 7; i++) step();
        run_instr(OP_IMM, 3'b000, 32'd2, 32'h77, 32'd0, 0, 32'd0, 1'b0);
        check("late_valid_pc", pc, 32'h104);

        do_reset();
        run_instr(OP_LOAD, 3'b000, 32'd0, 32'h4000, 32'd0, 3, 32'h1111_2222, 1'b1);
        do_reset();

        for (int i = 0; i < 15; i++) run_instr(OP_IMM, 3'b000, 32'd1, 32'(i), 32'd0, 0, 32'd0, 1'b0);
        check("retired_all_ones", 32'(retired), 32'hF);
        run_instr(OP_IMM, 3'b000, 32'd1, 32'h99, 32'd0, 0, 32'd0, 1'b0);
        check("retired_wrap", 32'(retired), 32'd0);

        check("latency_shortcircuit", 32'(sc_lat), 32'd3);
        check("latency_no_shortcircuit", 32'(ns_lat), 32'd4);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
